// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings,
// FSM states and the default operand width / iteration count.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_STEPS = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic op_is_signed(md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage handshake between the pipeline (master) and the muldiv
// sequencer (slave), including the architectural HI/LO read-back.
interface muldiv_if import muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
);

  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             rd_req;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, rd_req,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, rd_req,
    output stall, busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_iter.sv
// One combinational iteration: shift-add multiply or restoring divide on the
// {acc, q} pair. acc holds the product high half / partial remainder.
module muldiv_iter import muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] opnd,
  input  logic             div_mode,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // The partial remainder stays below the divisor, so the subtraction result
  // always fits in WIDTH bits once shifted >= opnd.
  always_comb begin
    sum      = {1'b0, acc} + (q[0] ? {1'b0, opnd} : '0);
    shifted  = {acc, q[WIDTH-1]};
    diff     = shifted[WIDTH-1:0] - opnd;
    acc_next = acc;
    q_next   = q;
    if (div_mode) begin
      if (shifted >= {1'b0, opnd}) begin
        acc_next = diff;
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = sum[WIDTH:1];
      q_next   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; signed ops run on magnitudes
// and the signs are applied in the FIX state.
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH,
  parameter int STEPS = MD_STEPS
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  md_state_e          state, state_next;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc, q, opnd, acc_step, q_step;
  logic [WIDTH-1:0]   hi, lo, abs_a, abs_b, quot, rem;
  logic [2*WIDTH-1:0] prod;
  logic               div_mode, neg_q, neg_r, done, sgn_op;
  logic               accept, finish, write_hi, write_lo;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .acc      (acc),
    .q        (q),
    .opnd     (opnd),
    .div_mode (div_mode),
    .acc_next (acc_step),
    .q_next   (q_step)
  );

  assign sgn_op = op_is_signed(bus.op);
  assign abs_a  = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b  = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign prod   = neg_q ? -{acc, q} : {acc, q};
  assign quot   = neg_q ? -q : q;
  assign rem    = neg_r ? -acc : acc;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Flush wins over everything, including a same-cycle start or the FIX write.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              MD_MTHI: write_hi = 1'b1;
              MD_MTLO: write_lo = 1'b1;
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                accept     = 1'b1;
                state_next = RUN;
              end
              default: ;
            endcase
          end
        end
        RUN:     if (cnt == LAST) state_next = FIX;
        FIX: begin
          finish     = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.busy | (bus.rd_req & bus.busy) | (bus.start & bus.busy);
  assign bus.done  = done;
  assign bus.hi    = hi;
  assign bus.lo    = lo;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        cnt      <= '0;
        acc      <= '0;
        div_mode <= op_is_div(bus.op);
        neg_q    <= sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        neg_r    <= sgn_op & bus.a[WIDTH-1];
        if (op_is_div(bus.op)) begin
          q    <= abs_a;
          opnd <= abs_b;
        end else begin
          q    <= abs_b;
          opnd <= abs_a;
        end
      end else if (state == RUN) begin
        acc <= acc_step;
        q   <= q_step;
        cnt <= cnt + 1'b1;
      end
      if (write_hi) hi <= bus.a;
      if (write_lo) lo <= bus.a;
      if (finish) begin
        if (div_mode) begin
          hi <= rem;
          lo <= quot;
        end else begin
          hi <= prod[2*WIDTH-1:WIDTH];
          lo <= prod[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: a behavioural arithmetic model predicts
// {hi,lo} at issue time and a negedge monitor checks each done pulse.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W   = MD_WIDTH;
  localparam int LAT = MD_STEPS + 1;

  typedef struct {
    logic [63:0] res;
    int          startCyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   errors = 0;
  exp_t sbq[$];
  exp_t e;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_ctrl #(.WIDTH(W), .STEPS(MD_STEPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(md_op_e op, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return {32'd0, a} * {32'd0, b};
      MD_DIVU:  return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      MD_DIV: begin
        if (b == 32'd0) return {a, (a[31] ? 32'h1 : 32'hFFFF_FFFF)};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default:  return 64'd0;
    endcase
  endfunction

  // Every done pulse must match the oldest outstanding prediction and arrive
  // exactly STEPS+1 edges after the accepting edge.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        checkOutput("result", {bus.hi, bus.lo}, e.res);
        checkOutput("latency", 64'(cyc - e.startCyc), 64'(LAT));
      end
    end
  end

  task automatic applyStimulus(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                               input bit track);
    int   guard;
    exp_t x;
    guard = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    #1;
    while (bus.stall && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) checkOutput("accept_timeout", 64'd1, 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    if (track && (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU})) begin
      x.res      = model(op, a, b);
      x.startCyc = cyc;
      sbq.push_back(x);
    end
  endtask

  task automatic runOp(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    int stallCycles;
    int guard;
    stallCycles = 0;
    guard = 0;
    applyStimulus(op, a, b, 1'b1);
    while (!bus.done && guard < 100) begin
      if (bus.stall) stallCycles++;
      @(negedge clk);
      guard++;
    end
    checkOutput("stall_cycles", 64'(stallCycles), 64'(LAT));
    checkOutput("stall_at_done", 64'(bus.stall), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    md_op_e rop;
    logic [31:0] ra, rb;
    bus.start  = 1'b0;
    bus.op     = MD_MULT;
    bus.a      = '0;
    bus.b      = '0;
    bus.flush  = 1'b0;
    bus.rd_req = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_hi", 64'(bus.hi), 64'd0);
    checkOutput("reset_lo", 64'(bus.lo), 64'd0);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_stall", 64'(bus.stall), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    rst = 1'b1;

    runOp(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    checkOutput("multu_max", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
    runOp(MD_MULT, -32'sd3, 32'd5);
    checkOutput("mult_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    runOp(MD_DIV, -32'sd7, 32'd2);
    checkOutput("div_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp(MD_DIVU, 32'd100, 32'd0);
    checkOutput("divu_zero", {bus.hi, bus.lo}, 64'h0000_0064_FFFF_FFFF);
    runOp(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("div_wrap", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

    // MTHI then MTLO back to back: single-cycle, never stalls.
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MTHI; bus.a = 32'h1234;
    #1 checkOutput("mthi_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.op = MD_MTLO; bus.a = 32'h5678;
    #1 checkOutput("mtlo_stall", 64'(bus.stall), 64'd0);
    checkOutput("mthi_hi", 64'(bus.hi), 64'h1234);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("mtlo_hilo", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);

    // Same-cycle MTHI and MFHI read: the read sees the old value.
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MTHI; bus.a = 32'hABCD; bus.rd_req = 1'b1;
    #1 checkOutput("rd_old_hi", 64'(bus.hi), 64'h1234);
    checkOutput("rd_idle_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.rd_req = 1'b0;
    checkOutput("rd_new_hi", 64'(bus.hi), 64'hABCD);

    // Flush mid-iteration.
    applyStimulus(MD_DIVU, 32'd1000, 32'd3, 1'b0);
    repeat (8) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush_busy", 64'(bus.busy), 64'd0);
    checkOutput("flush_hilo", {bus.hi, bus.lo}, 64'h0000_ABCD_0000_5678);
    repeat (40) @(negedge clk);

    // Flush landing on the FIX cycle discards the result.
    applyStimulus(MD_MULTU, 32'd3, 32'd4, 1'b0);
    repeat (LAT - 1) @(negedge clk);
    checkOutput("fix_busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("fixflush_busy", 64'(bus.busy), 64'd0);
    checkOutput("fixflush_done", 64'(bus.done), 64'd0);
    checkOutput("fixflush_hilo", {bus.hi, bus.lo}, 64'h0000_ABCD_0000_5678);

    // Flush beats a same-cycle start.
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MULT; bus.a = 32'd5; bus.b = 32'd5; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    checkOutput("flushstart_busy", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);
    checkOutput("flushstart_hilo", {bus.hi, bus.lo}, 64'h0000_ABCD_0000_5678);

    // MFLO stalled by an in-flight MULTU releases on the done cycle.
    applyStimulus(MD_MULTU, 32'd6, 32'd7, 1'b1);
    @(negedge clk);
    bus.rd_req = 1'b1;
    guard = 0;
    #1;
    while (bus.stall && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rdreq_done", 64'(bus.done), 64'd1);
    checkOutput("rdreq_lo", 64'(bus.lo), 64'd42);
    bus.rd_req = 1'b0;

    // Second op presented while busy is held and issued afterwards.
    applyStimulus(MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);
    applyStimulus(MD_DIVU, 32'hFFFF_FFFF, 32'd16, 1'b1);

    for (int i = 0; i < 6; i++) begin
      rop = md_op_e'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
      runOp(rop, ra, rb);
    end

    // Reset in the middle of an iteration clears everything.
    applyStimulus(MD_MULTU, 32'd9, 32'd9, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
    checkOutput("midreset_busy", 64'(bus.busy), 64'd0);
    checkOutput("midreset_stall", 64'(bus.stall), 64'd0);
    checkOutput("midreset_done", 64'(bus.done), 64'd0);
    rst = 1'b1;

    runOp(MD_DIVU, 32'd42, 32'd5);
    checkOutput("post_reset_divu", {bus.hi, bus.lo}, 64'h0000_0002_0000_0008);

    guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
